// File: rtl/sobel_stream_engine.sv
// Streams a raster image from a source BRAM to a destination BRAM, either copying it (MOVE) or writing a 3x3 Sobel magnitude (SOBEL).
// Defining SOBEL_THRESH_EN adds the i_thresh port and the binary threshold mode (i_mode=2).
module sobel_stream_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WIDTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [ADDR_WIDTH-1:0] i_width,
  input  logic [ADDR_WIDTH-1:0] i_height,
`ifdef SOBEL_THRESH_EN
  input  logic [DATA_WIDTH-1:0] i_thresh,
`endif
  output logic                  o_idle,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  rd_ce,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_q,
  output logic                  wr_ce,
  output logic                  wr_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_d
);

  localparam int CW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int TW = ADDR_WIDTH + 2;
  localparam int GW = DATA_WIDTH + 3;
  localparam int MW = DATA_WIDTH + 4;
  localparam int PW = 2 * ADDR_WIDTH;
  localparam logic [PW-1:0]         AREA_MAX  = PW'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] WIDTH_MAX = ADDR_WIDTH'(MAX_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] DIM_MIN   = ADDR_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] PIX_MAX   = {DATA_WIDTH{1'b1}};
  localparam logic [MW-1:0]         MAG_SAT   = {4'b0000, {DATA_WIDTH{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                  state_reg, state_next;
  logic [PW-1:0]           area;
  logic                    mode_ok, cfg_ok, accept, busy, emit;
  logic [TW-1:0]           t_reg;
  logic [TW-1:0]           n_last_reg, emit_first_reg, emit_last_reg, flush_end_reg;
  logic [ADDR_WIDTH-1:0]   w_reg, h_reg, col_reg;
  logic [ADDR_WIDTH-1:0]   out_idx_reg, out_col_reg, out_row_reg;
  logic [CW-1:0]           col_d_reg;
  logic [1:0]              mode_reg;
  logic                    err_reg, wr_ce_reg;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg;
  logic [DATA_WIDTH-1:0]   wr_d_reg;
`ifdef SOBEL_THRESH_EN
  logic [DATA_WIDTH-1:0]   thresh_reg;
`endif

  logic [DATA_WIDTH-1:0]   lb1_mem [MAX_WIDTH];
  logic [DATA_WIDTH-1:0]   lb2_mem [MAX_WIDTH];
  logic [DATA_WIDTH-1:0]   lb1_q_reg, lb2_q_reg;
  logic [2:0][DATA_WIDTH-1:0]      col_in;
  logic [2:0][2:0][DATA_WIDTH-1:0] win;

  logic [GW-1:0]           gx, gy, abs_gx, abs_gy;
  logic [MW-1:0]           mag;
  logic [DATA_WIDTH-1:0]   mag_sat, pix_out;
  logic                    border;

  // Start legality check on the raw inputs.
  always_comb begin
    area = PW'(i_width) * PW'(i_height);
`ifdef SOBEL_THRESH_EN
    mode_ok = 1'b1;
`else
    mode_ok = (i_mode != 2'd2);
`endif
    cfg_ok = (i_width >= DIM_MIN) && (i_height >= DIM_MIN) &&
             (i_width <= WIDTH_MAX) && (area <= AREA_MAX) && mode_ok;
    accept = (state_reg == S_IDLE) && i_start && cfg_ok;
  end

  always_comb begin
    state_next = state_reg;
    o_idle     = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    rd_ce      = 1'b0;
    rd_addr    = '0;
    case (state_reg)
      S_IDLE: begin
        o_idle = 1'b1;
        if (accept) state_next = S_RUN;
      end
      S_RUN: begin
        o_busy  = 1'b1;
        rd_ce   = 1'b1;
        rd_addr = t_reg[ADDR_WIDTH-1:0];
        if (t_reg == n_last_reg) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        o_busy = 1'b1;
        if (t_reg == flush_end_reg) state_next = S_DONE;
      end
      S_DONE: begin
        o_done     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // t_reg counts cycles since RUN entry: read k happens at t=k, output m is formed at t=m+W+3.
  assign busy = (state_reg == S_RUN) || (state_reg == S_FLUSH);
  assign emit = busy && (t_reg >= emit_first_reg) && (t_reg <= emit_last_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      t_reg       <= '0;
      col_reg     <= '0;
      err_reg     <= 1'b0;
      wr_ce_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_d_reg    <= '0;
      out_idx_reg <= '0;
      out_col_reg <= '0;
      out_row_reg <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= (state_reg == S_IDLE) && i_start && !cfg_ok;
      wr_ce_reg <= emit;
      if (accept) begin
        t_reg       <= '0;
        col_reg     <= '0;
        out_idx_reg <= '0;
        out_col_reg <= '0;
        out_row_reg <= '0;
      end else if (busy) begin
        t_reg   <= t_reg + TW'(1);
        col_reg <= (col_reg == w_reg - ADDR_WIDTH'(1)) ? '0 : col_reg + ADDR_WIDTH'(1);
      end
      if (emit) begin
        wr_addr_reg <= out_idx_reg;
        wr_d_reg    <= pix_out;
        out_idx_reg <= out_idx_reg + ADDR_WIDTH'(1);
        if (out_col_reg == w_reg - ADDR_WIDTH'(1)) begin
          out_col_reg <= '0;
          out_row_reg <= out_row_reg + ADDR_WIDTH'(1);
        end else begin
          out_col_reg <= out_col_reg + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Run configuration and precomputed phase boundaries, captured on an accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      w_reg          <= i_width;
      h_reg          <= i_height;
      mode_reg       <= i_mode;
      n_last_reg     <= TW'(area) - TW'(1);
      emit_first_reg <= TW'(i_width) + TW'(3);
      emit_last_reg  <= TW'(area) + TW'(i_width) + TW'(2);
      flush_end_reg  <= TW'(area) + TW'(i_width) + TW'(3);
`ifdef SOBEL_THRESH_EN
      thresh_reg     <= i_thresh;
`endif
    end
  end

  // Line buffers: the read is issued alongside the source read so both words land in the same cycle.
  always_ff @(posedge clk) begin
    if (busy) begin
      lb1_q_reg <= lb1_mem[col_reg[CW-1:0]];
      lb2_q_reg <= lb2_mem[col_reg[CW-1:0]];
      col_d_reg <= col_reg[CW-1:0];
    end
    if (busy && (t_reg != '0)) begin
      lb1_mem[col_d_reg] <= rd_q;
      lb2_mem[col_d_reg] <= lb1_q_reg;
    end
  end

  assign col_in = {rd_q, lb1_q_reg, lb2_q_reg};

  // Window row gi holds three horizontally adjacent taps; row 0 is the oldest image row.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_win_row
      logic [2:0][DATA_WIDTH-1:0] taps_reg;
      always_ff @(posedge clk) begin
        if (busy) taps_reg <= {col_in[gi], taps_reg[2], taps_reg[1]};
      end
      assign win[gi] = taps_reg;
    end
  endgenerate

  always_comb begin
    gx = (GW'(win[0][2]) + (GW'(win[1][2]) << 1) + GW'(win[2][2])) -
         (GW'(win[0][0]) + (GW'(win[1][0]) << 1) + GW'(win[2][0]));
    gy = (GW'(win[0][0]) + (GW'(win[0][1]) << 1) + GW'(win[0][2])) -
         (GW'(win[2][0]) + (GW'(win[2][1]) << 1) + GW'(win[2][2]));
    abs_gx  = gx[GW-1] ? (~gx + GW'(1)) : gx;
    abs_gy  = gy[GW-1] ? (~gy + GW'(1)) : gy;
    mag     = MW'(abs_gx) + MW'(abs_gy);
    mag_sat = (mag > MAG_SAT) ? PIX_MAX : mag[DATA_WIDTH-1:0];
    border  = (out_row_reg == '0) || (out_row_reg == h_reg - ADDR_WIDTH'(1)) ||
              (out_col_reg == '0) || (out_col_reg == w_reg - ADDR_WIDTH'(1));
    pix_out = '0;
    case (mode_reg)
      2'd0: pix_out = win[1][1];
`ifdef SOBEL_THRESH_EN
      2'd2: pix_out = border ? '0 : ((mag_sat >= thresh_reg) ? PIX_MAX : '0);
`endif
      default: pix_out = border ? '0 : mag_sat;
    endcase
  end

  assign o_err   = err_reg;
  assign wr_ce   = wr_ce_reg;
  assign wr_we   = wr_ce_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_d    = wr_d_reg;

endmodule
